// File: rtl/axi4lite_slave_regfile_if.sv
// AXI4-Lite five-channel bundle between a master and the register-file responder.
// Carries handshake, address, data and response fields only; clock and reset stay outside.
interface axi4lite_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite responder mapping a small register file, contents exported on reg_out.
// Write: commit on last of AW/W, BVALID next cycle. Read: RVALID one cycle after AR. Responses held until accepted.
module axi4lite_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    axi4lite_slave_regfile_if.slave        axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign axi.AWREADY = awready_q;
    assign axi.WREADY  = wready_q;
    assign axi.BVALID  = bvalid_q;
    assign axi.BRESP   = bresp_q;
    assign axi.ARREADY = arready_q;
    assign axi.RVALID  = rvalid_q;
    assign axi.RDATA   = rdata_q;
    assign axi.RRESP   = rresp_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    logic                  aw_hs, w_hs, commit, wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_word, rd_word;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

    assign aw_hs  = axi.AWVALID && awready_q;
    assign w_hs   = axi.WVALID && wready_q;
    assign commit = (wr_state == WR_IDLE    && aw_hs && w_hs) ||
                    (wr_state == WR_WAIT_W  && w_hs) ||
                    (wr_state == WR_WAIT_AW && aw_hs);

    // Whichever half arrived first comes from the capture registers, the other live from the bus.
    assign wr_addr = (wr_state == WR_WAIT_W)  ? aw_addr_q : axi.AWADDR;
    assign wr_data = (wr_state == WR_WAIT_AW) ? wdata_q   : axi.WDATA;
    assign wr_strb = (wr_state == WR_WAIT_AW) ? wstrb_q   : axi.WSTRB;
    assign wr_word = wr_addr >> ADDR_LSB;
    assign wr_ok   = wr_word < ADDR_WIDTH'(NUM_REGS);
    assign wr_idx  = wr_word[IDX_W-1:0];

    assign rd_word = axi.ARADDR >> ADDR_LSB;
    assign rd_ok   = rd_word < ADDR_WIDTH'(NUM_REGS);
    assign rd_idx  = rd_word[IDX_W-1:0];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state  <= WR_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            if (wr_ok) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
            bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            bvalid_q  <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wr_state  <= WR_RESP;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= axi.AWADDR;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wr_state  <= WR_WAIT_W;
                    end else if (w_hs) begin
                        wdata_q   <= axi.WDATA;
                        wstrb_q   <= axi.WSTRB;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b0;
                        wr_state  <= WR_WAIT_AW;
                    end else begin
                        // Also arms the readies on the first cycle out of reset.
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (axi.BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_state  <= WR_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reads sample regs before any same-edge commit lands, so they see the pre-write value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (axi.ARVALID && arready_q) begin
                        rdata_q   <= rd_ok ? regs[rd_idx] : '0;
                        rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rd_state  <= RD_RESP;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (axi.RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_state  <= RD_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Directed bench for axi4lite_slave_regfile: handshake ordering, strobes, range errors,
// held responses and mid-transaction reset, checked with immediate assertions.
module tb_axi4lite_slave_regfile;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;

    logic ACLK = 1'b0;
    logic ARESET;
    logic [NR*DW-1:0] reg_out;
    logic [NR*DW-1:0] exp_regs;
    int errors = 0;
    int checks = 0;

    axi4lite_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi4lite_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .axi    (axi.slave),
        .reg_out(reg_out)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        axi.AWADDR  = '0; axi.AWVALID = 1'b0;
        axi.WDATA   = '0; axi.WSTRB   = '0; axi.WVALID = 1'b0;
        axi.ARADDR  = '0; axi.ARVALID = 1'b0;
    endtask

    // Same-cycle AW+W with BREADY high, runs through the B handshake.
    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        axi.AWADDR = a; axi.AWVALID = 1'b1;
        axi.WDATA  = d; axi.WSTRB   = s; axi.WVALID = 1'b1;
        axi.BREADY = 1'b1;
        tick();
        idle_bus();
        tick();
    endtask

    initial begin
        ARESET = 1'b1;
        idle_bus();
        axi.BREADY = 1'b0;
        axi.RREADY = 1'b0;
        exp_regs = '0;
        tick();
        tick();
        check("rst_awready", axi.AWREADY, 0);
        check("rst_wready",  axi.WREADY,  0);
        check("rst_arready", axi.ARREADY, 0);
        check("rst_valids",  {axi.BVALID, axi.RVALID}, 0);
        check("rst_regout",  reg_out, 0);
        ARESET = 1'b0;
        tick();
        check("post_rst_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b111);

        // Simultaneous AW+W to word1
        axi.AWADDR = 32'h4; axi.AWVALID = 1'b1;
        axi.WDATA = 32'hDEADBEEF; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
        axi.BREADY = 1'b1;
        tick();
        idle_bus();
        exp_regs[1*DW +: DW] = 32'hDEADBEEF;
        check("wr1_bvalid", axi.BVALID, 1);
        check("wr1_bresp",  axi.BRESP, 2'b00);
        check("wr1_readies_low", {axi.AWREADY, axi.WREADY}, 2'b00);
        check("wr1_regout", reg_out, exp_regs);
        tick();
        check("wr1_b_done", {axi.BVALID, axi.AWREADY, axi.WREADY}, 3'b011);

        axi.ARADDR = 32'h4; axi.ARVALID = 1'b1; axi.RREADY = 1'b1;
        tick();
        axi.ARVALID = 1'b0;
        check("rd1_rvalid", axi.RVALID, 1);
        check("rd1_rdata",  axi.RDATA, 32'hDEADBEEF);
        check("rd1_rresp",  axi.RRESP, 2'b00);
        check("rd1_arready_low", axi.ARREADY, 0);
        tick();
        check("rd1_done", {axi.RVALID, axi.ARREADY}, 2'b01);

        // W three cycles ahead of AW
        axi.WDATA = 32'h11223344; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
        tick();
        axi.WVALID = 1'b0;
        check("wfirst_readies", {axi.AWREADY, axi.WREADY}, 2'b10);
        check("wfirst_no_b", axi.BVALID, 0);
        tick();
        tick();
        check("wfirst_wait_regout", reg_out, exp_regs);
        axi.AWADDR = 32'h8; axi.AWVALID = 1'b1;
        tick();
        axi.AWVALID = 1'b0;
        exp_regs[2*DW +: DW] = 32'h11223344;
        check("wfirst_bvalid", axi.BVALID, 1);
        check("wfirst_regout", reg_out, exp_regs);
        tick();

        // AW three cycles ahead of W
        axi.AWADDR = 32'h8; axi.AWVALID = 1'b1;
        tick();
        axi.AWVALID = 1'b0;
        check("awfirst_readies", {axi.AWREADY, axi.WREADY}, 2'b01);
        tick();
        tick();
        axi.WDATA = 32'hCAFEF00D; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
        tick();
        axi.WVALID = 1'b0;
        exp_regs[2*DW +: DW] = 32'hCAFEF00D;
        check("awfirst_bvalid", {axi.BVALID, axi.BRESP}, 3'b100);
        check("awfirst_regout", reg_out, exp_regs);
        tick();

        // Byte strobes
        write_word(32'hC, 32'hFFFFFFFF, 4'hF);
        write_word(32'hC, 32'h00000000, 4'b0101);
        exp_regs[3*DW +: DW] = 32'hFF00FF00;
        check("strobe_regout", reg_out, exp_regs);
        check("strobe_bresp", axi.BRESP, 2'b00);

        // Out of range
        axi.AWADDR = 32'h40; axi.AWVALID = 1'b1;
        axi.WDATA = 32'hA5A5A5A5; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
        tick();
        idle_bus();
        check("oor_wr_b", {axi.BVALID, axi.BRESP}, 3'b110);
        check("oor_wr_regout", reg_out, exp_regs);
        tick();
        axi.ARADDR = 32'h40; axi.ARVALID = 1'b1;
        tick();
        axi.ARVALID = 1'b0;
        check("oor_rd_rvalid", axi.RVALID, 1);
        check("oor_rd_rdata", axi.RDATA, 0);
        check("oor_rd_rresp", axi.RRESP, 2'b10);
        tick();

        // BREADY held low while a read completes
        axi.BREADY = 1'b0;
        axi.AWADDR = 32'h10; axi.AWVALID = 1'b1;
        axi.WDATA = 32'h0BADCAFE; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
        tick();
        idle_bus();
        exp_regs[4*DW +: DW] = 32'h0BADCAFE;
        check("hold_regout", reg_out, exp_regs);
        axi.ARADDR = 32'h4; axi.ARVALID = 1'b1;
        tick();
        axi.ARVALID = 1'b0;
        check("hold_rd_data", {axi.RVALID, axi.RDATA}, {1'b1, 32'hDEADBEEF});
        for (int i = 0; i < 10; i++) begin
            check("hold_b_stable", {axi.BVALID, axi.BRESP, axi.AWREADY, axi.WREADY}, 5'b10000);
            tick();
        end
        check("hold_rd_done", {axi.RVALID, axi.ARREADY}, 2'b01);
        axi.BREADY = 1'b1;
        tick();
        check("hold_release", {axi.BVALID, axi.AWREADY, axi.WREADY}, 3'b011);

        // Reset with a half-captured write and a pending read response
        axi.RREADY = 1'b0;
        axi.AWADDR = 32'h4; axi.AWVALID = 1'b1;
        axi.ARADDR = 32'h8; axi.ARVALID = 1'b1;
        tick();
        idle_bus();
        check("pre_rst_state", {axi.AWREADY, axi.WREADY, axi.RVALID}, 3'b011);
        ARESET = 1'b1;
        tick();
        check("mid_rst_outputs",
              {axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID, axi.BRESP, axi.RRESP, axi.RDATA}, 0);
        check("mid_rst_regout", reg_out, 0);
        ARESET = 1'b0;
        tick();
        check("rel_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b111);
        check("rel_no_resp", {axi.BVALID, axi.RVALID}, 2'b00);
        // Lone W must not pair with the discarded pre-reset address
        axi.WDATA = 32'h12345678; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
        tick();
        axi.WVALID = 1'b0;
        check("rel_no_stale_commit", {axi.BVALID, axi.WREADY, axi.AWREADY}, 3'b001);
        check("rel_regout", reg_out, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
